// File: rtl/hazard_scheduler_pkg.sv
// Shared constants for the pipeline interlock controller:
// opcode map, IF/ID instruction field positions and scoreboard sizing.
package hazard_scheduler_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;
    localparam int HAZ_DIST = 3;
    localparam int CNT_W    = 16;
    localparam int SB_W     = 2;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 29;
    localparam int RDST_HI = 23;
    localparam int RDST_LO = 21;
    localparam int RSRC_HI = 20;
    localparam int RSRC_LO = 18;

    localparam logic [2:0] OPC_SYS  = 3'b000;
    localparam logic [2:0] OPC_LDM  = 3'b001;
    localparam logic [2:0] OPC_ALU1 = 3'b010;
    localparam logic [2:0] OPC_ALU2 = 3'b011;
    localparam logic [2:0] OPC_MEM  = 3'b100;
    localparam logic [2:0] OPC_NOP  = 3'b101;
    localparam logic [2:0] OPC_BR   = 3'b110;
    localparam logic [2:0] OPC_IO   = 3'b111;

    typedef struct packed {
        logic [2:0]       opc;
        logic [REG_W-1:0] rdst;
        logic [REG_W-1:0] rsrc;
    } id_fields_t;

    // Pull the fields the interlock cares about out of an IF/ID word.
    function automatic id_fields_t decode_id(input logic [31:0] instr);
        id_fields_t f;
        f.opc  = instr[OPC_HI:OPC_LO];
        f.rdst = instr[RDST_HI:RDST_LO];
        f.rsrc = instr[RSRC_HI:RSRC_LO];
        return f;
    endfunction

endpackage

// File: rtl/hazard_scheduler_scoreboard.sv
// Per-register countdown scoreboard: a loaded counter marks a write
// in flight until it drains to zero, one step per clock.
import hazard_scheduler_pkg::*;

module reg_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3,
    parameter int CW       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [IDX_W-1:0]    load_idx,
    input  logic [CW-1:0]       load_val,
    output logic [NUM_REGS-1:0] pending
);

    logic [CW-1:0] cnt [NUM_REGS];

    // Reload the issuing writer's counter; every other live counter drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load && (load_idx == IDX_W'(i))) begin
                    cnt[i] <= load_val;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // A register is pending while its counter is nonzero.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending[i] = |cnt[i];
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// RAW interlock: holds fetch and bubbles ID/EX while an operand of the
// IF/ID instruction still has a write in flight.
import hazard_scheduler_pkg::*;

module hazard_scheduler #(
    parameter int         NUM_REGS   = 8,
    parameter int         HAZ_DIST   = 3,
    parameter int         CNT_W      = 16,
    parameter logic [2:0] NOP_OPCODE = 3'b101
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         id_instr,
    input  logic                id_wb,
    input  logic                id_rd_src,
    input  logic                id_rd_dst,
    input  logic                flush,
    output logic                stall_if,
    output logic                bubble,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    stall_count
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    id_fields_t f;
    logic       valid_id;
    logic       haz;
    logic       sb_load;
    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       unused_bits;

    assign f           = decode_id(id_instr);
    assign unused_bits = ^{id_instr[28:24], id_instr[17:0]};

    // Valid, non-NOP, unflushed instruction checked against the scoreboard.
    always_comb begin
        valid_id = (f.opc != NOP_OPCODE) & ~flush;
        haz      = valid_id
                 & ((id_rd_src & pending[f.rsrc])
                 |  (id_rd_dst & pending[f.rdst]));
        sb_load  = valid_id & ~haz & id_wb;
    end

    // Outputs are held quiet while reset is asserted.
    always_comb begin
        stall_if = haz & ~rst;
        bubble   = (haz | flush) & ~rst;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_W),
        .CW       (SB_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .load     (sb_load),
        .load_idx (f.rdst),
        .load_val (SB_W'(HAZ_DIST - 1)),
        .pending  (pending)
    );

    // Next interlock state from the current hazard.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (haz)  state_nxt = ST_STALL;
            ST_STALL: if (!haz) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Interlock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_if && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for the RAW interlock: back-to-back, spaced, WAW,
// flush and asynchronous reset scenarios with hand-computed results.
module tb_hazard_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_wb;
    logic        id_rd_src;
    logic        id_rd_dst;
    logic        flush;
    logic        stall_if;
    logic        bubble;
    logic [7:0]  pending;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    hazard_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .id_instr    (id_instr),
        .id_wb       (id_wb),
        .id_rd_src   (id_rd_src),
        .id_rd_dst   (id_rd_dst),
        .flush       (flush),
        .stall_if    (stall_if),
        .bubble      (bubble),
        .pending     (pending),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] opc, input logic [2:0] rd,
                         input logic [2:0] rs, input logic wb,
                         input logic rsrc, input logic rdst,
                         input logic fl);
        id_instr  = {opc, 5'b0, rd, rs, 18'b0};
        id_wb     = wb;
        id_rd_src = rsrc;
        id_rd_dst = rdst;
        flush     = fl;
    endtask

    task automatic nop();
        drive(3'b101, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        #1;
        chk("rst_stall", stall_if, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_pending", pending, 0);
        chk("rst_count", stall_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back RAW; consumer also writes R7
        @(negedge clk);
        drive(3'b001, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("b2b_prod_stall", stall_if, 0);
        @(negedge clk);
        drive(3'b011, 3'd7, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("b2b_stall1", stall_if, 1);
        chk("b2b_bubble1", bubble, 1);
        chk("b2b_pend1", pending, 8'h80);
        @(negedge clk);
        #1 chk("b2b_stall2", stall_if, 1);
        @(negedge clk);
        #1 chk("b2b_issue", stall_if, 0);
        chk("b2b_issue_bub", bubble, 0);
        chk("b2b_pend3", pending, 0);
        chk("b2b_count", stall_count, 2);
        @(negedge clk);
        nop();
        #1 chk("b2b_reload", pending, 8'h80);

        // distance satisfied; NOP with wb set must not load
        @(negedge clk);
        drive(3'b001, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("dist_waw_nostall", stall_if, 0);
        @(negedge clk);
        drive(3'b101, 3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 chk("dist_nop1", stall_if, 0);
        @(negedge clk);
        #1 chk("dist_nop2", stall_if, 0);
        @(negedge clk);
        drive(3'b010, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("dist_pend", pending, 0);
        chk("dist_stall", stall_if, 0);
        @(negedge clk);
        nop();
        #1 chk("dist_count", stall_count, 2);

        // distance 2
        @(negedge clk);
        drive(3'b001, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(3'b010, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("d2_indep", stall_if, 0);
        @(negedge clk);
        drive(3'b010, 3'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("d2_stall", stall_if, 1);
        chk("d2_pend", pending, 8'h20);
        @(negedge clk);
        #1 chk("d2_issue", stall_if, 0);
        chk("d2_count", stall_count, 3);
        @(negedge clk);
        nop();

        // WAW reload
        @(negedge clk);
        drive(3'b010, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(3'b010, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("waw_nostall", stall_if, 0);
        chk("waw_pend", pending, 8'h08);
        @(negedge clk);
        drive(3'b010, 3'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("waw_stall1", stall_if, 1);
        @(negedge clk);
        #1 chk("waw_stall2", stall_if, 1);
        @(negedge clk);
        #1 chk("waw_issue", stall_if, 0);
        chk("waw_count", stall_count, 5);
        @(negedge clk);
        nop();

        // flush during hazard
        @(negedge clk);
        drive(3'b001, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(3'b010, 3'd4, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("fl_bubble", bubble, 1);
        chk("fl_stall", stall_if, 0);
        chk("fl_pend", pending, 8'h04);
        @(negedge clk);
        nop();
        #1 chk("fl_noload", pending, 8'h04);
        @(negedge clk);
        #1 chk("fl_drain", pending, 0);
        chk("fl_count", stall_count, 5);

        // asynchronous reset mid-stall
        @(negedge clk);
        drive(3'b001, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(3'b010, 3'd1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk("ar_stall", stall_if, 1);
        #1 rst = 1'b1;
        #1 chk("ar_stall0", stall_if, 0);
        chk("ar_bubble0", bubble, 0);
        chk("ar_pend0", pending, 0);
        chk("ar_count0", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ar_held", stall_if, 0);
        @(negedge clk);
        nop();
        #1 chk("ar_issued", pending, 8'h02);
        chk("ar_count", stall_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
Interlock controller for the 5-stage pipeline (IF/ID -> ID/EX -> EX/MEM -> MEM/WB). It tracks in-flight register writes in a per-register countdown scoreboard. It detects read-after-write hazards on the instruction currently in the IF/ID buffer, then holds fetch and injects a NOP bubble into ID/EX until the producer's result reaches the register file. This replaces hand-inserted NOP pairs in instruction streams.

Parameters:
NUM_REGS, 8, architectural registers (index width 3)
HAZ_DIST, 3, minimum ID-stage issue distance between producer and consumer (2 bubbles)
CNT_W, 16, width of stall statistics counter
NOP_OPCODE, 3'b101, value of instr[31:29] that denotes NOP

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
id_instr  in  32  IF/ID buffer: [31:29] opcode, [23:21] Rdst, [20:18] Rsrc
id_wb  in  1  CU write-back control for id_instr
id_rd_src  in  1  id_instr reads Rsrc
id_rd_dst  in  1  id_instr reads Rdst (two-operand ALU ops)
flush  in  1  kill instruction in ID this cycle
stall_if  out  1  hold PC and IF/ID buffer
bubble  out  1  force ID/EX control bits (WB,MW,MR,ALU,ALUOp) to 0
pending  out  NUM_REGS  bit r = register r has a write in flight
stall_count  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- One clock (clk); reset rst asynchronous, active-high.
- Reset: all scoreboard counters 0, pending 0, stall_count 0, FSM = RUN. While rst is high, stall_if and bubble are forced to 0.
- Scoreboard: per register a 2-bit counter cnt[r]; pending[r] = (cnt[r] != 0).
- Hazard (combinational, same cycle): haz = valid_id & ((id_rd_src & pending[Rsrc]) | (id_rd_dst & pending[Rdst])), where valid_id = (opcode != NOP_OPCODE) & ~flush.
- stall_if = haz. bubble = haz | flush.
- Issue: the ID instruction issues when valid_id & ~haz. If it also has id_wb, then cnt[Rdst] <= HAZ_DIST-1 at the clock edge.
- Every clock edge, each nonzero cnt[r] not being reloaded decrements by 1. Reload wins over decrement for the same register in the same cycle.
- Writer to an already-pending Rdst (WAW): the counter is reloaded to HAZ_DIST-1. No stall.
- An instruction whose own Rdst is pending and which reads Rdst stalls first, then issues and reloads the counter.
- NOP opcode: never stalls, never loads the scoreboard, regardless of id_wb.
- flush: the ID instruction does not issue (bubble=1, stall_if=0, no scoreboard load). In-flight counters keep decrementing, because older instructions still write back.
- FSM:
  - RUN -> STALL when haz.
  - STALL -> RUN when ~haz.
  - State is exposed only through stall_count behaviour.
  - Max consecutive stall cycles = HAZ_DIST-1.
- stall_count increments on each clock edge where stall_if=1 and saturates at all-ones.
- Latency: a producer issued at edge t lets a dependent consumer issue at edge t+HAZ_DIST. The consumer sees exactly HAZ_DIST-1 stall cycles if it follows immediately, and 0 if it arrives HAZ_DIST or more instructions later.
- Reset mid-stall: outputs drop to 0 immediately (asynchronous). The scoreboard clears, and the held instruction issues on the first edge after rst deasserts.

Decomposition:
- Shared package/header: opcode constants (NOP_OPCODE and the CU category codes); instruction field position constants (OPC_HI/LO=31/29, RDST=23:21, RSRC=20:18); HAZ_DIST.
- One natural sub-module: reg_scoreboard. It holds the NUM_REGS countdown counters, with load (index), decrement and pending-vector output.
- Hazard compare, FSM and stats counter stay in hazard_scheduler.

Test Plan:
- Back-to-back RAW:
  - Stimulus: LDM R7 (opc 001, id_wb=1, Rdst=7), then opc 011 reading R7 via Rdst (id_rd_dst=1).
  - Expected: stall_if=bubble=1 for exactly 2 cycles, consumer issues on the 3rd cycle, stall_count=2.
- Distance satisfied:
  - Stimulus: producer R7, two unrelated NOPs (opc 101), then consumer of R7.
  - Expected: zero stalls, pending[7] clear when consumer arrives, stall_count unchanged.
- Distance 2:
  - Stimulus: producer R5, one independent instr, consumer of R5.
  - Expected: exactly 1 stall cycle.
- WAW reload:
  - Stimulus: writer R3 then writer R3 next cycle, then reader of R3.
  - Expected: no stall between the writers; reader stalls 2 cycles measured from the second writer.
- Flush during hazard:
  - Stimulus: producer R2, then dependent instr with flush=1.
  - Expected: bubble=1, stall_if=0, no stall_count increment; cnt[2] still counts down to 0 in 2 cycles.
- Async reset mid-stall:
  - Stimulus: assert rst during the first stall cycle.
  - Expected: stall_if, bubble and pending go to 0 without a clock edge; stall_count=0; held instruction issues on the first edge after release.
